// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, prot default and master state type
package axil_pkg;

    localparam logic [1:0] AXIL_OKAY         = 2'b00;
    localparam logic [1:0] AXIL_SLVERR       = 2'b10;
    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } axil_mst_state_t;

endpackage

// File: rtl/axil_lite_master.sv
// rtl/axil_lite_master.sv - single-outstanding AXI4-Lite master behind a simple req/resp port
module axil_lite_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic [CNT_WIDTH-1:0]  wr_done_count,
    output logic [CNT_WIDTH-1:0]  rd_done_count
);

    import axil_pkg::*;

    axil_mst_state_t       state, state_n;

    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_n;
    logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic                  aw_done, aw_done_n, w_done, w_done_n;
    logic                  req_ready_n, resp_valid_n, resp_err_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n;
    logic [CNT_WIDTH-1:0]  wr_cnt_n, rd_cnt_n;

    // The request is latched once, so both address channels and W are driven straight from flops
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = AXIL_PROT_DEFAULT;
    assign m_axil_arprot = AXIL_PROT_DEFAULT;

    // State and every output register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            wr_done_count  <= '0;
            rd_done_count  <= '0;
        end else begin
            state          <= state_n;
            addr_q         <= addr_n;
            wdata_q        <= wdata_n;
            wstrb_q        <= wstrb_n;
            m_axil_awvalid <= awvalid_n;
            m_axil_wvalid  <= wvalid_n;
            m_axil_bready  <= bready_n;
            m_axil_arvalid <= arvalid_n;
            m_axil_rready  <= rready_n;
            aw_done        <= aw_done_n;
            w_done         <= w_done_n;
            req_ready      <= req_ready_n;
            resp_valid     <= resp_valid_n;
            resp_rdata     <= resp_rdata_n;
            resp_err       <= resp_err_n;
            wr_done_count  <= wr_cnt_n;
            rd_done_count  <= rd_cnt_n;
        end
    end

    // Next-state and next-output decode; everything holds unless a handshake moves it
    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        wstrb_n      = wstrb_q;
        awvalid_n    = m_axil_awvalid;
        wvalid_n     = m_axil_wvalid;
        bready_n     = m_axil_bready;
        arvalid_n    = m_axil_arvalid;
        rready_n     = m_axil_rready;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        req_ready_n  = req_ready;
        resp_valid_n = resp_valid;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        wr_cnt_n     = wr_done_count;
        rd_cnt_n     = rd_done_count;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_n      = req_addr;
                    wdata_n     = req_wdata;
                    wstrb_n     = req_wstrb;
                    aw_done_n   = 1'b0;
                    w_done_n    = 1'b0;
                    req_ready_n = 1'b0;
                    if (req_wr) begin
                        state_n   = ST_WRITE;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        bready_n  = 1'b1;
                    end else begin
                        state_n   = ST_READ;
                        arvalid_n = 1'b1;
                        rready_n  = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                // AW and W retire independently; each valid stays up until its own flag is set
                aw_done_n = aw_done | (m_axil_awvalid & m_axil_awready);
                w_done_n  = w_done  | (m_axil_wvalid  & m_axil_wready);
                awvalid_n = ~aw_done_n;
                wvalid_n  = ~w_done_n;
                if (m_axil_bvalid && m_axil_bready) begin
                    state_n      = ST_RESP;
                    awvalid_n    = 1'b0;
                    wvalid_n     = 1'b0;
                    bready_n     = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = '0;
                    resp_err_n   = (m_axil_bresp != AXIL_OKAY);
                    wr_cnt_n     = wr_done_count + CNT_WIDTH'(1);
                end
            end

            ST_READ: begin
                if (m_axil_arvalid && m_axil_arready) begin
                    arvalid_n = 1'b0;
                end
                if (m_axil_rvalid && m_axil_rready) begin
                    state_n      = ST_RESP;
                    arvalid_n    = 1'b0;
                    rready_n     = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = m_axil_rdata;
                    resp_err_n   = (m_axil_rresp != AXIL_OKAY);
                    rd_cnt_n     = rd_done_count + CNT_WIDTH'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_n      = ST_IDLE;
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// tb/tb_axil_lite_master.sv - self-checking bench for axil_lite_master with a delay-configurable slave
module tb_axil_lite_master;
    import axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          resp_valid, resp_ready = 1'b0, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]    m_axil_awprot, m_axil_arprot;
    logic          m_axil_awvalid, m_axil_awready;
    logic [DW-1:0] m_axil_wdata, m_axil_rdata;
    logic [SW-1:0] m_axil_wstrb;
    logic          m_axil_wvalid, m_axil_wready;
    logic [1:0]    m_axil_bresp, m_axil_rresp;
    logic          m_axil_bvalid, m_axil_bready;
    logic          m_axil_arvalid, m_axil_arready;
    logic          m_axil_rvalid, m_axil_rready;
    logic [CW-1:0] wr_done_count, rd_done_count;

    axil_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
        .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready), .wr_done_count(wr_done_count), .rd_done_count(rd_done_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int acc_cyc = 0;

    // slave knobs, set by the driver before each request
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit err_inj = 1'b0;

    // slave internals
    bit            aw_got, w_got, ar_got, b_prev, r_prev;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] smem [0:63];

    // reference model: word memory and wrapping completion counts
    logic [DW-1:0] mmem [0:63];
    int            m_wr = 0, m_rd = 0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        bit            err;
        int            hold;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_wr_cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic s_reset();
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rresp = 2'b00; m_axil_rdata = '0;
        aw_got = 0; w_got = 0; ar_got = 0; b_prev = 0; r_prev = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    endtask

    // Behavioural slave: decides everything at the falling edge so the DUT sees stable inputs
    initial begin
        for (int i = 0; i < 64; i++) smem[i] = '0;
        s_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_reset();
            end else begin
                if (m_axil_awready) begin
                    m_axil_awready = 1'b0; aw_got = 1;
                end else if (m_axil_awvalid && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin m_axil_awready = 1'b1; s_awaddr = m_axil_awaddr; aw_cnt = 0; end
                    else aw_cnt++;
                end
                if (m_axil_wready) begin
                    m_axil_wready = 1'b0; w_got = 1;
                end else if (m_axil_wvalid && !w_got) begin
                    if (w_cnt >= w_dly) begin
                        m_axil_wready = 1'b1; s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb; w_cnt = 0;
                    end else w_cnt++;
                end
                if (m_axil_bvalid) begin
                    if (b_prev) begin m_axil_bvalid = 1'b0; aw_got = 0; w_got = 0; end
                    else b_prev = m_axil_bready;
                end else if (aw_got && w_got) begin
                    if (b_cnt >= b_dly) begin
                        m_axil_bvalid = 1'b1; b_prev = m_axil_bready; b_cnt = 0;
                        m_axil_bresp = err_inj ? AXIL_SLVERR : AXIL_OKAY;
                        if (!err_inj)
                            for (int b = 0; b < SW; b++)
                                if (s_wstrb[b]) smem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    end else b_cnt++;
                end
                if (m_axil_arready) begin
                    m_axil_arready = 1'b0; ar_got = 1;
                end else if (m_axil_arvalid && !ar_got) begin
                    if (ar_cnt >= ar_dly) begin m_axil_arready = 1'b1; s_araddr = m_axil_araddr; ar_cnt = 0; end
                    else ar_cnt++;
                end
                if (m_axil_rvalid) begin
                    if (r_prev) begin m_axil_rvalid = 1'b0; ar_got = 0; end
                    else r_prev = m_axil_rready;
                end else if (ar_got) begin
                    if (r_cnt >= r_dly) begin
                        m_axil_rvalid = 1'b1; r_prev = m_axil_rready; r_cnt = 0;
                        m_axil_rdata = smem[s_araddr[7:2]];
                        m_axil_rresp = err_inj ? AXIL_SLVERR : AXIL_OKAY;
                    end else r_cnt++;
                end
            end
        end
    end

    task automatic send_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] wstrb);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic complete_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] wstrb, input int hold);
        int t = 0;
        int lat, exp_lat;
        logic [DW-1:0] exp_rd, rd0;
        logic e0;
        while (!resp_valid && t < 200) begin @(negedge clk); t++; end
        lat = cyc - acc_cyc;
        chk("resp_seen", resp_valid, 1);
        if (wr) begin
            exp_lat = 2 + imax(aw_dly, w_dly) + b_dly;
            exp_rd  = '0;
            if (!err_inj)
                for (int b = 0; b < SW; b++)
                    if (wstrb[b]) mmem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
            m_wr = (m_wr + 1) % 16;
            chk("fwd_awaddr", s_awaddr, addr);
            chk("fwd_wdata", s_wdata, wdata);
            chk("fwd_wstrb", s_wstrb, wstrb);
        end else begin
            exp_lat = 2 + ar_dly + r_dly;
            exp_rd  = mmem[addr[7:2]];
            m_rd = (m_rd + 1) % 16;
            chk("fwd_araddr", s_araddr, addr);
        end
        chk("latency", lat, exp_lat);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", resp_err, err_inj);
        chk("wr_done_count", wr_done_count, m_wr);
        chk("rd_done_count", rd_done_count, m_rd);
        rd0 = resp_rdata;
        e0  = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_err", resp_err, e0);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] wstrb, input bit err, input int hold);
        err_inj = err;
        send_req(wr, addr, wdata, wstrb);
        complete_txn(wr, addr, wdata, wstrb, hold);
    endtask

    initial begin
        tbl[0] = '{1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 32'h00000000, 0, 1};
        tbl[1] = '{0, 16'h0010, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 0, 1};
        tbl[2] = '{1, 16'h0010, 32'h00000055, 4'h1, 0, 0, 32'h00000000, 0, 2};
        tbl[3] = '{0, 16'h0010, 32'h0,        4'h0, 0, 0, 32'hDEADBE55, 0, 2};
        tbl[4] = '{0, 16'h0010, 32'h0,        4'h0, 1, 5, 32'hDEADBE55, 1, 2};
        tbl[5] = '{1, 16'h0014, 32'h12345678, 4'hA, 1, 1, 32'h00000000, 1, 3};
        tbl[6] = '{0, 16'h0014, 32'h0,        4'h0, 0, 2, 32'h00000000, 0, 3};
        for (int i = 0; i < 64; i++) mmem[i] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, resp_valid}, 0);
        chk("rst_readies", {m_axil_bready, m_axil_rready}, 0);
        chk("rst_counts", {wr_done_count, rd_done_count}, 0);
        chk("rst_resp", {resp_rdata, resp_err}, 0);
        chk("rst_latched", {m_axil_awaddr, m_axil_wdata, m_axil_wstrb}, 0);
        rst_n = 1'b1;
        chk("prot", {m_axil_awprot, m_axil_arprot}, 0);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].err, tbl[i].hold);
            chk($sformatf("tbl%0d_rdata", i), resp_rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), resp_err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_wrcnt", i), wr_done_count, tbl[i].exp_wr_cnt);
        end

        // W accepted three cycles before AW
        aw_dly = 3; w_dly = 0; b_dly = 0; err_inj = 0;
        send_req(1, 16'h0020, 32'hA5A5A5A5, 4'hF);
        chk("indep_both_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        @(negedge clk);
        chk("indep_wvalid_drop", m_axil_wvalid, 0);
        for (int i = 0; i < 3; i++) begin
            chk("indep_awvalid_held", m_axil_awvalid, 1);
            chk("indep_awaddr_stable", m_axil_awaddr, 16'h0020);
            chk("indep_bready", m_axil_bready, 1);
            @(negedge clk);
        end
        complete_txn(1, 16'h0020, 32'hA5A5A5A5, 4'hF, 0);
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin @(negedge clk); if (resp_valid) pulses++; end
            chk("indep_single_resp", pulses, 0);
        end
        aw_dly = 0;

        // reset while the write is still waiting on AW and W
        aw_dly = 5; w_dly = 5;
        send_req(1, 16'h0030, 32'h11223344, 4'hF);
        chk("rstmid_awvalid_before", m_axil_awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 0);
        chk("rstmid_counts", {wr_done_count, rd_done_count}, 0);
        m_wr = 0; m_rd = 0;
        aw_dly = 0; w_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_req_ready", req_ready, 1);
        chk("rstmid_no_resp", resp_valid, 0);

        // 17 reads wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) run_txn(0, 16'h0010, '0, '0, 0, 0);
        chk("wrap_rd_cnt", rd_done_count, 4'd1);

        for (int i = 0; i < 80; i++) begin
            bit            wr;
            logic [AW-1:0] addr;
            wr     = 1'($urandom_range(0, 1));
            addr   = AW'($urandom_range(0, 15) * 4);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            run_txn(wr, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
